// File: rtl/urna_voting_fsm.sv
// Ballot-box controller: collects a 4-digit BCD code through Valid strobes and
// commits it on Finish into one of four candidate tallies or the null tally.
// Optional build macro: URNA_SATURATE_EN (tallies saturate instead of wrapping).
module urna_voting_fsm #(
  parameter logic [15:0] CAND1 = 16'h3494,
  parameter logic [15:0] CAND2 = 16'h3485,
  parameter logic [15:0] CAND3 = 16'h3472,
  parameter logic [15:0] CAND4 = 16'h3504,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [3:0]       Digit,
  input  logic             Valid,
  input  logic             Finish,
  output logic [CNT_W-1:0] C1,
  output logic [CNT_W-1:0] C2,
  output logic [CNT_W-1:0] C3,
  output logic [CNT_W-1:0] C4,
  output logic [CNT_W-1:0] Nulo,
  output logic             Status
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D1   = 3'd1,
    D2   = 3'd2,
    D3   = 3'd3,
    D4   = 3'd4,
    OVF  = 3'd5
  } state_e;

  // Tally indices: the four candidates first, the null tally last.
  typedef enum logic [2:0] {
    TGT_NONE = 3'd0,
    TGT_C1   = 3'd1,
    TGT_C2   = 3'd2,
    TGT_C3   = 3'd3,
    TGT_C4   = 3'd4,
    TGT_NULO = 3'd5
  } target_e;

  localparam int unsigned N_TALLY = 5;

  state_e           state_q, state_d;
  logic [15:0]      digits_q, digits_d;
  logic             valid_q;
  logic             status_q, status_d;
  logic [CNT_W-1:0] tally_q [N_TALLY];
  logic [CNT_W-1:0] tally_d [N_TALLY];
  logic             accept;
  target_e          target;

  function automatic target_e decode_vote(input state_e st, input logic [15:0] code);
    target_e t;
    case (st)
      IDLE: t = TGT_NONE;
      D4: begin
        if      (code == CAND1) t = TGT_C1;
        else if (code == CAND2) t = TGT_C2;
        else if (code == CAND3) t = TGT_C3;
        else if (code == CAND4) t = TGT_C4;
        else                    t = TGT_NULO;
      end
      default: t = TGT_NULO;
    endcase
    return t;
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef URNA_SATURATE_EN
    return (&v) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // A digit is taken on the falling edge of the strobe as seen by two samples.
  assign accept = valid_q & ~Valid;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    digits_d = digits_q;
    target   = TGT_NONE;

    if (Finish) begin
      target   = decode_vote(state_q, digits_q);
      state_d  = IDLE;
      digits_d = '0;
    end else if (accept) begin
      digits_d = {digits_q[11:0], Digit};
      case (state_q)
        IDLE:    state_d = D1;
        D1:      state_d = D2;
        D2:      state_d = D3;
        D3:      state_d = D4;
        default: state_d = OVF;
      endcase
    end

    status_d = (state_d != IDLE);

    for (int i = 0; i < N_TALLY; i++) begin
      tally_d[i] = tally_q[i];
      if (target == target_e'(3'(i + 1))) tally_d[i] = bump(tally_q[i]);
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!Reset_n) begin
      state_q  <= IDLE;
      digits_q <= '0;
      valid_q  <= 1'b0;
      status_q <= 1'b0;
      // NOTE: the tally array is a handful of flops, not a RAM, and the
      // results must read zero after reset, so every entry is cleared.
      for (int i = 0; i < N_TALLY; i++) tally_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= Valid;
      status_q <= status_d;
      for (int i = 0; i < N_TALLY; i++) tally_q[i] <= tally_d[i];
    end
  end

  assign C1     = tally_q[0];
  assign C2     = tally_q[1];
  assign C3     = tally_q[2];
  assign C4     = tally_q[3];
  assign Nulo   = tally_q[4];
  assign Status = status_q;

endmodule

// File: tb/tb_urna_voting_fsm.sv
// Self-checking bench for urna_voting_fsm: a queue-based ballot model checked
// every cycle, plus directed votes with hand-computed tally expectations.
module tb_urna_voting_fsm;

  localparam int CNT_W = 8;

  logic             Clock;
  logic             Reset_n;
  logic [3:0]       Digit;
  logic             Valid;
  logic             Finish;
  logic [CNT_W-1:0] C1, C2, C3, C4, Nulo;
  logic             Status;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 0;

  urna_voting_fsm dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .Digit  (Digit),
    .Valid  (Valid),
    .Finish (Finish),
    .C1     (C1),
    .C2     (C2),
    .C3     (C3),
    .C4     (C4),
    .Nulo   (Nulo),
    .Status (Status)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ballot model: the digits typed so far, and the five tallies as integers.
  int m_tally [5];
  int digq [$];
  bit m_prev_valid;

  function automatic void m_vote(input int idx);
`ifdef URNA_SATURATE_EN
    if (m_tally[idx] < 255) m_tally[idx]++;
`else
    m_tally[idx] = (m_tally[idx] + 1) % 256;
`endif
  endfunction

  always @(posedge Clock) begin
    if (!Reset_n) begin
      foreach (m_tally[i]) m_tally[i] = 0;
      digq.delete();
      m_prev_valid = 1'b0;
    end else begin
      if (Finish) begin
        if (digq.size() == 4) begin
          int code;
          code = digq[0] * 4096 + digq[1] * 256 + digq[2] * 16 + digq[3];
          if      (code == 'h3494) m_vote(0);
          else if (code == 'h3485) m_vote(1);
          else if (code == 'h3472) m_vote(2);
          else if (code == 'h3504) m_vote(3);
          else                     m_vote(4);
        end else if (digq.size() > 0) begin
          m_vote(4);
        end
        digq.delete();
      end else if (m_prev_valid && !Valid) begin
        if (digq.size() < 5) digq.push_back(int'(Digit));
      end
      m_prev_valid = Valid;
    end
  end

  always @(negedge Clock) begin
    if (checking) begin
      check("model_c1",     int'(C1),     m_tally[0]);
      check("model_c2",     int'(C2),     m_tally[1]);
      check("model_c3",     int'(C3),     m_tally[2]);
      check("model_c4",     int'(C4),     m_tally[3]);
      check("model_nulo",   int'(Nulo),   m_tally[4]);
      check("model_status", int'(Status), (digq.size() > 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic press(input int d);
    Digit = 4'(d);
    Valid = 1'b1;
    tick();
    Valid = 1'b0;
    tick();
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic commit();
    Finish = 1'b1;
    tick();
    Finish = 1'b0;
    tick();
  endtask

  task automatic check_all(input string tag, input int e1, input int e2, input int e3,
                           input int e4, input int en, input int es);
    check({tag, "_c1"},     int'(C1),     e1);
    check({tag, "_c2"},     int'(C2),     e2);
    check({tag, "_c3"},     int'(C3),     e3);
    check({tag, "_c4"},     int'(C4),     e4);
    check({tag, "_nulo"},   int'(Nulo),   en);
    check({tag, "_status"}, int'(Status), es);
  endtask

  initial begin
    Reset_n = 1'b0;
    Valid   = 1'b0;
    Finish  = 1'b0;
    Digit   = 4'd0;
    tick();
    checking = 1'b1;
    tick();
    check_all("reset", 0, 0, 0, 0, 0, 0);
    Reset_n = 1'b1;
    tick();

    // Empty ballot is ignored.
    commit();
    check_all("empty", 0, 0, 0, 0, 0, 0);

    // Vote for candidate 1.
    press(3);
    check("first_digit_status", int'(Status), 1);
    press(4); press(9); press(4);
    check("d4_status", int'(Status), 1);
    commit();
    check_all("cand1", 1, 0, 0, 0, 0, 0);

    // Candidates 2, 3, 4.
    enter4(3, 4, 8, 5); commit();
    enter4(3, 4, 7, 2); commit();
    enter4(3, 5, 0, 4); commit();
    check_all("cand234", 1, 1, 1, 1, 0, 0);

    // Two digits, then Finish held three edges while Valid stays high.
    press(3); press(0);
    Digit = 4'd7;
    Valid = 1'b1;
    tick();
    Finish = 1'b1;
    tick(); tick(); tick();
    Finish = 1'b0;
    tick();
    check_all("short", 1, 1, 1, 1, 1, 0);
    // The pending fall of Valid opens a new ballot with the digit 7.
    Valid = 1'b0;
    tick();
    check("late_fall_status", int'(Status), 1);

    // Six digits in total: overflow ballot is null.
    enter4(3, 4, 9, 4); press(1); commit();
    check_all("ovf", 1, 1, 1, 1, 2, 0);

    // Four digits that match no candidate.
    enter4(1, 2, 3, 4); commit();
    check_all("nomatch", 1, 1, 1, 1, 3, 0);

    // Finish on the same edge as a digit accept: digit dropped, D3 -> null.
    press(3); press(4); press(9);
    Digit  = 4'd4;
    Valid  = 1'b1;
    tick();
    Valid  = 1'b0;
    Finish = 1'b1;
    tick();
    Finish = 1'b0;
    check_all("finish_prio", 1, 1, 1, 1, 4, 0);
    tick();
    check("finish_prio_after", int'(Status), 0);

    // Reset in mid-vote discards everything.
    press(3); press(4); press(9);
    Reset_n = 1'b0;
    tick(); tick();
    Reset_n = 1'b1;
    check_all("midreset", 0, 0, 0, 0, 0, 0);
    tick();
    enter4(3, 4, 9, 4); commit();
    check_all("post_reset", 1, 0, 0, 0, 0, 0);

    // Non-BCD digits are accepted but can only produce a null vote.
    enter4(10, 11, 12, 13); commit();
    enter4(3, 4, 9, 15); commit();
    check_all("hex", 1, 0, 0, 0, 2, 0);

    // Counter boundary: 256 votes for candidate 1 after a fresh reset.
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    for (int v = 0; v < 255; v++) begin
      enter4(3, 4, 9, 4);
      commit();
    end
    check("c1_255", int'(C1), 255);
    enter4(3, 4, 9, 4); commit();
`ifdef URNA_SATURATE_EN
    check("c1_256", int'(C1), 255);
`else
    check("c1_256", int'(C1), 0);
`endif
    check("c1_256_nulo", int'(Nulo), 0);
    tick();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
